// File: rtl/clk_sync_pkg.sv
`default_nettype none
// ============================================================================
// Package : clk_sync_pkg
// Brief   : Shared widths, minimum divide value and config record for the
//           clock-sync dividers.
// Rev     : 1.0 - initial release
// ============================================================================
package clk_sync_pkg;

    localparam int CNT_W_DEF  = 32;
    localparam int FRAC_W_DEF = 12;
    localparam int MIN_N_DEF  = 2;

    typedef struct packed {
        logic [CNT_W_DEF-1:0]  n;
        logic [FRAC_W_DEF-1:0] rem;
        logic [CNT_W_DEF-1:0]  duty;
    } cfg_t;

endpackage
`default_nettype wire

// File: rtl/frac_n_divider_if.sv
`default_nettype none
// ============================================================================
// Interface : frac_n_divider_if
// Brief     : valid/ready configuration channel of the fractional-N divider.
// Rev       : 1.0 - initial release
// ============================================================================
interface frac_n_divider_if
    import clk_sync_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) ();

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cfg_n;
    logic [FRAC_W-1:0] cfg_rem;
    logic [CNT_W-1:0]  cfg_duty;

    modport master (
        output cfg_valid,
        output cfg_n,
        output cfg_rem,
        output cfg_duty,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_n,
        input  cfg_rem,
        input  cfg_duty,
        output cfg_ready
    );

endinterface
`default_nettype wire

// File: rtl/frac_n_divider_sd_accum_1st.sv
`default_nettype none
// ============================================================================
// Module : sd_accum_1st
// Brief  : First-order sigma-delta phase accumulator; carry is the dither bit.
// Rev    : 1.0 - initial release
// ============================================================================
module sd_accum_1st
    import clk_sync_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  wire logic              clk_in,
    input  wire logic              reset,
    input  wire logic              clear,
    input  wire logic              step_en,
    input  wire logic [FRAC_W-1:0] step,
    output logic                   carry,
    output logic                   carry_next
);

    logic [FRAC_W:0]   w_sum;
    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W-1:0] acc_d;
    logic              carry_q;
    logic              carry_d;

    // clear wins over step so a re-phase always starts from zero phase
    always_comb begin
        w_sum   = {1'b0, acc_q} + {1'b0, step};
        acc_d   = acc_q;
        carry_d = carry_q;
        if (clear) begin
            acc_d   = '0;
            carry_d = 1'b0;
        end else if (step_en) begin
            acc_d   = w_sum[FRAC_W-1:0];
            carry_d = w_sum[FRAC_W];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    assign carry      = carry_q;
    assign carry_next = w_sum[FRAC_W];

endmodule
`default_nettype wire

// File: rtl/frac_n_divider.sv
`default_nettype none
// ============================================================================
// Module : frac_n_divider
// Brief  : Fractional-N clock divider with programmable duty, shadowed
//          reconfiguration at period boundaries and external re-phase.
// Rev    : 1.0 - initial release
// ============================================================================
module frac_n_divider
    import clk_sync_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int MIN_N  = MIN_N_DEF
) (
    input  wire logic        clk_in,
    input  wire logic        reset,
    input  wire logic        enable,
    frac_n_divider_if.slave  cfg,
    input  wire logic        sync,
    output logic             clk_out,
    output logic             period_start,
    output logic             cfg_applied,
    output logic [CNT_W:0]   period_len
);

    typedef struct packed {
        logic [CNT_W-1:0]  n;
        logic [FRAC_W-1:0] rem;
        logic [CNT_W-1:0]  duty;
    } cfg_int_t;

    localparam logic [CNT_W-1:0] c_min_n   = CNT_W'(MIN_N);
    localparam logic [CNT_W:0]   c_one     = (CNT_W+1)'(1);
    localparam cfg_int_t         c_cfg_rst = '{n: c_min_n, rem: {FRAC_W{1'b0}}, duty: {CNT_W{1'b0}}};

    logic [CNT_W:0] count_q, count_d;
    cfg_int_t       act_q, act_d;
    cfg_int_t       shadow_q, shadow_d;
    logic           shadow_full_q, shadow_full_d;
    logic           ready_q, ready_d;
    logic           restart_q, restart_d;
    logic           clk_out_q, clk_out_d;
    logic           period_start_q, period_start_d;
    logic           cfg_applied_q, cfg_applied_d;
    logic [CNT_W:0] period_len_q, period_len_d;

    logic           w_carry;
    logic           w_carry_next;
    logic           w_acc_step_en;
    logic           w_start;
    logic           w_wrap;
    logic           w_accept;
    logic           w_extra_new;
    logic [CNT_W:0] w_count_inc;
    logic [CNT_W:0] w_len_cur;
    logic [CNT_W:0] w_duty_cur_eff;
    logic [CNT_W:0] w_len_new;
    logic [CNT_W:0] w_duty_new_eff;
    logic [CNT_W-1:0] w_clamped_n;
    cfg_int_t       w_new;

    // Widened by one bit so n = 2^CNT_W-1 plus a dither cycle still fits.
    assign w_len_cur      = {1'b0, act_q.n} + {{CNT_W{1'b0}}, w_carry};
    assign w_duty_cur_eff = ({1'b0, act_q.duty} < w_len_cur) ? {1'b0, act_q.duty} : (w_len_cur - c_one);
    assign w_count_inc    = count_q + c_one;
    assign w_wrap         = (w_count_inc == w_len_cur);
    assign w_start        = sync || restart_q;

    // Only a shadow that was full before this cycle may take effect now.
    assign w_new          = shadow_full_q ? shadow_q : act_q;
    assign w_extra_new    = w_start ? 1'b0 : w_carry_next;
    assign w_len_new      = {1'b0, w_new.n} + {{CNT_W{1'b0}}, w_extra_new};
    assign w_duty_new_eff = ({1'b0, w_new.duty} < w_len_new) ? {1'b0, w_new.duty} : (w_len_new - c_one);

    assign w_acc_step_en  = enable && !w_start && w_wrap;
    assign w_accept       = cfg.cfg_valid && ready_q;
    assign w_clamped_n    = (cfg.cfg_n < c_min_n) ? c_min_n : cfg.cfg_n;

    sd_accum_1st #(
        .FRAC_W (FRAC_W)
    ) u_sd_accum (
        .clk_in     (clk_in),
        .reset      (reset),
        .clear      (sync),
        .step_en    (w_acc_step_en),
        .step       (w_new.rem),
        .carry      (w_carry),
        .carry_next (w_carry_next)
    );

    always_comb begin
        count_d        = count_q;
        act_d          = act_q;
        shadow_d       = shadow_q;
        shadow_full_d  = shadow_full_q;
        ready_d        = ready_q;
        restart_d      = restart_q;
        clk_out_d      = 1'b0;
        period_start_d = 1'b0;
        cfg_applied_d  = 1'b0;
        period_len_d   = period_len_q;

        if (enable) begin
            if (w_start || w_wrap) begin
                count_d        = '0;
                act_d          = w_new;
                period_start_d = 1'b1;
                clk_out_d      = (w_duty_new_eff != '0);
                period_len_d   = w_len_new;
                restart_d      = 1'b0;
                if (shadow_full_q) begin
                    shadow_full_d = 1'b0;
                    cfg_applied_d = 1'b1;
                end
            end else begin
                count_d   = w_count_inc;
                clk_out_d = (w_count_inc < w_duty_cur_eff);
            end
        end else if (sync) begin
            // Frozen re-phase: state clears now, the new period starts on re-enable.
            count_d   = '0;
            restart_d = 1'b1;
        end

        if (cfg_applied_q) begin
            ready_d = 1'b1;
        end
        if (w_accept) begin
            shadow_d.n    = w_clamped_n;
            shadow_d.rem  = cfg.cfg_rem;
            shadow_d.duty = cfg.cfg_duty;
            shadow_full_d = 1'b1;
            ready_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            count_q        <= '0;
            act_q          <= c_cfg_rst;
            shadow_q       <= c_cfg_rst;
            shadow_full_q  <= 1'b0;
            ready_q        <= 1'b1;
            restart_q      <= 1'b0;
            clk_out_q      <= 1'b0;
            period_start_q <= 1'b0;
            cfg_applied_q  <= 1'b0;
            period_len_q   <= {1'b0, c_min_n};
        end else begin
            count_q        <= count_d;
            act_q          <= act_d;
            shadow_q       <= shadow_d;
            shadow_full_q  <= shadow_full_d;
            ready_q        <= ready_d;
            restart_q      <= restart_d;
            clk_out_q      <= clk_out_d;
            period_start_q <= period_start_d;
            cfg_applied_q  <= cfg_applied_d;
            period_len_q   <= period_len_d;
        end
    end

    assign cfg.cfg_ready = ready_q;
    assign clk_out       = clk_out_q;
    assign period_start  = period_start_q;
    assign cfg_applied   = cfg_applied_q;
    assign period_len    = period_len_q;

endmodule
`default_nettype wire

// File: tb/tb_frac_n_divider.sv
`default_nettype none
// ============================================================================
// Module : tb_frac_n_divider
// Brief  : Self-checking bench for frac_n_divider against an arithmetic model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_frac_n_divider;
    import clk_sync_pkg::*;

    localparam int CW = 32;
    localparam int FW = 12;
    localparam int MN = 2;

    logic          clk_in = 1'b0;
    logic          reset  = 1'b0;
    logic          enable = 1'b0;
    logic          sync   = 1'b0;
    logic          clk_out;
    logic          period_start;
    logic          cfg_applied;
    logic [CW:0]   period_len;

    int total = 0;
    int bad   = 0;
    int applied_cnt = 0;

    frac_n_divider_if #(.CNT_W(CW), .FRAC_W(FW)) cfg_if ();

    frac_n_divider #(.CNT_W(CW), .FRAC_W(FW), .MIN_N(MN)) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .enable       (enable),
        .cfg          (cfg_if),
        .sync         (sync),
        .clk_out      (clk_out),
        .period_start (period_start),
        .cfg_applied  (cfg_applied),
        .period_len   (period_len)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        #1;
        if (cfg_applied === 1'b1) applied_cnt++;
    end

    // Period k after a re-phase (k=0 is the re-phase period) gains one cycle
    // whenever k*rem crosses a multiple of 2^FW.
    function automatic int exp_len(input int n, input int rem, input int k);
        longint a, b;
        if (k == 0) return n;
        a = (longint'(k) * rem) >> FW;
        b = (longint'(k - 1) * rem) >> FW;
        return n + int'(a - b);
    endfunction

    function automatic int exp_high(input int duty, input int len);
        return (duty < len) ? duty : len - 1;
    endfunction

    task automatic offer(input int n, input int rem, input int duty);
        int guard = 0;
        while (cfg_if.cfg_ready !== 1'b1 && guard < 100) begin
            @(negedge clk_in);
            guard++;
        end
        if (guard >= 100) begin
            total++; bad++;
            $display("FAIL offer_timeout: cfg_ready=%b required 1", cfg_if.cfg_ready);
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_n     = CW'(n);
        cfg_if.cfg_rem   = FW'(rem);
        cfg_if.cfg_duty  = CW'(duty);
        @(negedge clk_in);
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        @(negedge clk_in);
        sync = 1'b0;
    endtask

    task automatic wait_start();
        int guard = 0;
        while (period_start !== 1'b1 && guard < 500) begin
            @(negedge clk_in);
            guard++;
        end
        if (guard >= 500) begin
            total++; bad++;
            $display("FAIL wait_start_timeout: period_start=%b required 1", period_start);
        end
    endtask

    // Entered on the cycle with period_start high; returns on the next one.
    task automatic measure(output int len, output int high, output logic [CW:0] plen);
        plen = period_len;
        len  = 0;
        high = 0;
        do begin
            if (clk_out === 1'b1) high++;
            len++;
            @(negedge clk_in);
        end while (period_start !== 1'b1 && len < 5000);
        if (len >= 5000) begin
            total++; bad++;
            $display("FAIL measure_timeout: len=%0d required <5000", len);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk_in);
        total++;
        if (clk_out !== 1'b0) begin bad++; $display("FAIL reset_clk_out: got %b want 0", clk_out); end
        total++;
        if (period_start !== 1'b0) begin bad++; $display("FAIL reset_period_start: got %b want 0", period_start); end
        total++;
        if (cfg_applied !== 1'b0) begin bad++; $display("FAIL reset_cfg_applied: got %b want 0", cfg_applied); end
        total++;
        if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_if.cfg_ready); end
        total++;
        if (period_len !== (CW+1)'(MN)) begin bad++; $display("FAIL reset_period_len: got %0d want %0d", period_len, MN); end
        reset = 1'b1;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_basic();
        int len, high, base, guard;
        logic [CW:0] plen;
        base = applied_cnt;
        offer(10, 0, 3);
        total++;
        if (cfg_if.cfg_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_drop: got %b want 0", cfg_if.cfg_ready); end
        guard = 0;
        while (cfg_applied !== 1'b1 && guard < 100) begin
            @(negedge clk_in);
            guard++;
        end
        total++;
        if (period_start !== 1'b1) begin bad++; $display("FAIL basic_applied_at_start: period_start=%b want 1", period_start); end
        for (int p = 0; p < 4; p++) begin
            measure(len, high, plen);
            total++;
            if (len !== 10 || high !== 3 || plen !== (CW+1)'(10)) begin
                bad++;
                $display("FAIL basic_period%0d: len=%0d high=%0d plen=%0d want 10/3/10", p, len, high, plen);
            end
        end
        total++;
        if (applied_cnt - base !== 1) begin bad++; $display("FAIL basic_applied_once: got %0d want 1", applied_cnt - base); end
    endtask

    task automatic test_duty_bounds();
        int cn[3]   = '{10, 10, 1};
        int cd[3]   = '{20, 0, 1};
        int elen[3] = '{10, 10, 2};
        int ehi[3]  = '{9, 0, 1};
        int len, high;
        logic [CW:0] plen;
        for (int c = 0; c < 3; c++) begin
            offer(cn[c], 0, cd[c]);
            repeat (3) @(negedge clk_in);
            pulse_sync();
            for (int p = 0; p < 3; p++) begin
                measure(len, high, plen);
                total++;
                if (len !== elen[c] || high !== ehi[c]) begin
                    bad++;
                    $display("FAIL duty_case%0d_p%0d: len=%0d high=%0d want %0d/%0d", c, p, len, high, elen[c], ehi[c]);
                end
            end
        end
    endtask

    task automatic test_midperiod();
        int len, high, cycles;
        logic [CW:0] plen;
        offer(10, 0, 3);
        repeat (3) @(negedge clk_in);
        pulse_sync();
        repeat (4) @(negedge clk_in);
        total++;
        if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_before: got %b want 1", cfg_if.cfg_ready); end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_n     = CW'(7);
        cfg_if.cfg_rem   = '0;
        cfg_if.cfg_duty  = CW'(2);
        @(negedge clk_in);
        total++;
        if (cfg_if.cfg_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_full1: got %b want 0", cfg_if.cfg_ready); end
        cfg_if.cfg_n    = CW'(5);
        cfg_if.cfg_duty = CW'(1);
        @(negedge clk_in);
        total++;
        if (cfg_if.cfg_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_full2: got %b want 0", cfg_if.cfg_ready); end
        @(negedge clk_in);
        cfg_if.cfg_valid = 1'b0;
        cycles = 7;
        while (period_start !== 1'b1 && cycles < 100) begin
            @(negedge clk_in);
            cycles++;
        end
        total++;
        if (cycles !== 10) begin bad++; $display("FAIL mid_old_period: len=%0d want 10", cycles); end
        total++;
        if (cfg_applied !== 1'b1) begin bad++; $display("FAIL mid_applied_at_wrap: got %b want 1", cfg_applied); end
        @(negedge clk_in);
        total++;
        if (cfg_if.cfg_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_return: got %b want 1", cfg_if.cfg_ready); end
        wait_start();
        for (int p = 0; p < 2; p++) begin
            measure(len, high, plen);
            total++;
            if (len !== 7 || high !== 2) begin
                bad++;
                $display("FAIL mid_new_period%0d: len=%0d high=%0d want 7/2", p, len, high);
            end
        end
    endtask

    task automatic test_sync();
        int len, high, sum, want_sum, first_bad;
        logic [CW:0] plen;
        offer(10, 2048, 3);
        repeat (2) @(negedge clk_in);
        pulse_sync();
        for (int p = 0; p < 2; p++) measure(len, high, plen);
        repeat (6) @(negedge clk_in);
        pulse_sync();
        total++;
        if (period_start !== 1'b1 || clk_out !== 1'b1 || period_len !== (CW+1)'(10)) begin
            bad++;
            $display("FAIL sync_rephase: start=%b clk_out=%b plen=%0d want 1/1/10", period_start, clk_out, period_len);
        end
        for (int k = 0; k < 5; k++) begin
            measure(len, high, plen);
            total++;
            if (len !== exp_len(10, 2048, k) || high !== 3 || plen !== (CW+1)'(exp_len(10, 2048, k))) begin
                bad++;
                $display("FAIL sync_period%0d: len=%0d high=%0d plen=%0d want %0d/3", k, len, high, plen, exp_len(10, 2048, k));
            end
        end
        pulse_sync();
        sum = 0;
        want_sum = 0;
        first_bad = -1;
        for (int k = 0; k < 2000; k++) begin
            measure(len, high, plen);
            sum += len;
            want_sum += exp_len(10, 2048, k);
            if (len !== exp_len(10, 2048, k) && first_bad < 0) first_bad = k;
        end
        total++;
        if (first_bad !== -1) begin bad++; $display("FAIL long_sequence: first wrong period=%0d want none", first_bad); end
        total++;
        if (sum !== want_sum || sum < 20990 || sum > 21010) begin
            bad++;
            $display("FAIL long_total: cycles=%0d want %0d (21000+-10)", sum, want_sum);
        end
    endtask

    task automatic test_random();
        cfg_t c;
        int n_eff, len, high, el, eh;
        logic [CW:0] plen;
        for (int t = 0; t < 6; t++) begin
            c.n    = CW'($urandom_range(0, 40));
            c.rem  = FW'($urandom_range(0, (1 << FW) - 1));
            c.duty = CW'($urandom_range(0, 45));
            n_eff  = (int'(c.n) < MN) ? MN : int'(c.n);
            offer(int'(c.n), int'(c.rem), int'(c.duty));
            repeat ($urandom_range(0, 12)) @(negedge clk_in);
            pulse_sync();
            for (int k = 0; k < 12; k++) begin
                measure(len, high, plen);
                el = exp_len(n_eff, int'(c.rem), k);
                eh = exp_high(int'(c.duty), el);
                total++;
                if (len !== el || high !== eh || plen !== (CW+1)'(el)) begin
                    bad++;
                    $display("FAIL rand_t%0d_k%0d: n=%0d rem=%0d duty=%0d len=%0d high=%0d plen=%0d want %0d/%0d",
                             t, k, c.n, c.rem, c.duty, len, high, plen, el, eh);
                end
            end
        end
    endtask

    task automatic test_enable();
        int len, high, cycles, gap_bad;
        logic [CW:0] plen;
        offer(10, 0, 5);
        repeat (2) @(negedge clk_in);
        pulse_sync();
        repeat (3) @(negedge clk_in);
        enable  = 1'b0;
        gap_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            if (clk_out !== 1'b0 || period_start !== 1'b0) gap_bad++;
        end
        enable = 1'b1;
        total++;
        if (gap_bad !== 0) begin bad++; $display("FAIL enable_gap: nonzero cycles=%0d want 0", gap_bad); end
        @(negedge clk_in);
        total++;
        if (clk_out !== 1'b1) begin bad++; $display("FAIL enable_resume_high: got %b want 1", clk_out); end
        cycles = 0;
        while (period_start !== 1'b1 && cycles < 100) begin
            @(negedge clk_in);
            cycles++;
        end
        total++;
        if (cycles !== 6) begin bad++; $display("FAIL enable_resume_count: remaining=%0d want 6", cycles); end
        repeat (2) @(negedge clk_in);
        enable = 1'b0;
        pulse_sync();
        total++;
        if (clk_out !== 1'b0 || period_start !== 1'b0) begin
            bad++;
            $display("FAIL disabled_sync_outputs: clk_out=%b start=%b want 0/0", clk_out, period_start);
        end
        @(negedge clk_in);
        enable = 1'b1;
        @(negedge clk_in);
        total++;
        if (period_start !== 1'b1 || clk_out !== 1'b1) begin
            bad++;
            $display("FAIL disabled_sync_restart: start=%b clk_out=%b want 1/1", period_start, clk_out);
        end
        measure(len, high, plen);
        total++;
        if (len !== 10 || high !== 5) begin bad++; $display("FAIL disabled_sync_period: len=%0d high=%0d want 10/5", len, high); end
    endtask

    task automatic test_reset_mid();
        int len, high, base;
        logic [CW:0] plen;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_n     = CW'(7);
        cfg_if.cfg_rem   = '0;
        cfg_if.cfg_duty  = CW'(2);
        @(negedge clk_in);
        cfg_if.cfg_valid = 1'b0;
        total++;
        if (cfg_if.cfg_ready !== 1'b0) begin bad++; $display("FAIL rstmid_accept: ready=%b want 0", cfg_if.cfg_ready); end
        repeat (4) @(negedge clk_in);
        reset = 1'b0;
        @(negedge clk_in);
        total++;
        if (clk_out !== 1'b0 || cfg_if.cfg_ready !== 1'b1 || period_start !== 1'b0 || period_len !== (CW+1)'(MN)) begin
            bad++;
            $display("FAIL rstmid_state: clk_out=%b ready=%b start=%b plen=%0d want 0/1/0/%0d",
                     clk_out, cfg_if.cfg_ready, period_start, period_len, MN);
        end
        reset = 1'b1;
        base  = applied_cnt;
        wait_start();
        for (int p = 0; p < 3; p++) begin
            measure(len, high, plen);
            total++;
            if (len !== MN || high !== 0) begin bad++; $display("FAIL rstmid_period%0d: len=%0d high=%0d want %0d/0", p, len, high, MN); end
        end
        total++;
        if (applied_cnt !== base) begin bad++; $display("FAIL rstmid_shadow_discard: applied=%0d want 0", applied_cnt - base); end
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_n     = '0;
        cfg_if.cfg_rem   = '0;
        cfg_if.cfg_duty  = '0;
        @(negedge clk_in);
        test_reset();
        test_basic();
        test_duty_bounds();
        test_midperiod();
        test_sync();
        test_random();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
